mat_ipv4_header_builder: RTL
============================

# mat_ipv4_header_builder

Transmit-side counterpart of the MAT packet dispatcher. It accepts a header-field descriptor and a payload AXI-Stream, and emits a complete Ethernet II + IPv4 frame on a 64-bit AXI-Stream master: a 34-byte header followed by the payload, realigned by 2 bytes. Source IP comes from `configurable_ipv4_address`, and the IPv4 header checksum is computed internally. It sits between the MAT result generators and the egress MAC path.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 64: stream width. Only 64 is supported.
- `AXIS_KEEP_WIDTH`, `AXIS_DATA_WIDTH/8`: tkeep width.

Ports:
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: asynchronous, active-low reset.
- `configurable_ipv4_address`, in, 32: IPv4 source address, sampled at header accept.
- `hdr_valid`, in, 1 / `hdr_ready`, out, 1: descriptor handshake.
- `hdr_mac_dest`, in, 48 / `hdr_mac_src`, in, 48: MAC addresses.
- `hdr_dscp`, in, 6 / `hdr_ecn`, in, 2 / `hdr_identifiant`, in, 16 / `hdr_ttl`, in, 8 / `hdr_protocol`, in, 8 / `hdr_dest_ipv4`, in, 32: IPv4 fields.
- `hdr_payload_length`, in, 16: payload bytes. Must be ≥1.
- `s_axis_tdata`, in, 64 / `s_axis_tkeep`, in, 8 / `s_axis_tvalid`, in, 1 / `s_axis_tready`, out, 1 / `s_axis_tlast`, in, 1: payload input.
- `m_axis_tdata`, out, 64 / `m_axis_tkeep`, out, 8 / `m_axis_tvalid`, out, 1 / `m_axis_tready`, in, 1 / `m_axis_tlast`, out, 1: frame output.
- `busy`, out, 1: high from header accept until the last output beat handshake.

## Operation
- **Byte order.** Lane 0 (`tdata[7:0]`) is the first byte on the wire. Every multi-byte field is sent MSB first.
- **Fixed fields.**
  - Ethertype is 0x0800.
  - Version/IHL byte is 0x45.
  - Byte 1 is {DSCP, ECN}.
  - Total length is `hdr_payload_length + 20`, modulo 2^16.
  - Flags/fragment offset is 0x4000 (DF).
- **Checksum.** One's-complement sum of the 10 header words with the checksum word taken as 0. Fold carries twice, then invert. A 32-bit accumulator is used.
- **Header beats.**
  - Beat 0: dst MAC[5:0] + src MAC bytes 0-1.
  - Beat 1: src MAC bytes 2-5 + ethertype + 0x45 + DSCP/ECN.
  - Beat 2: total length, identifiant, flags/frag, TTL, protocol.
  - Beat 3: checksum, src IP, dst IP bytes 0-1.
- **Merge.** Each merge beat is {2 carry bytes, input bytes 0-5}. The carry for the next beat is input bytes 6-7. The initial carry is dst IP bytes 2-3.
- **Payload tkeep.** Must be contiguous from lane 0. Only the tlast beat may be partial. `hdr_payload_length` is used only for the length field and is not checked against the stream.
- **States.**
  - IDLE: `hdr_ready`=1. Accept registers all fields → HEADER.
  - HEADER: beats 0-3, `s_axis_tready`=0. Beat 3 handshake → MERGE.
  - MERGE: `s_axis_tready` = `!m_axis_tvalid || m_axis_tready`.
    - On the input tlast beat with k valid bytes, if k≤6: output keep = (1<<(k+2))-1, tlast=1, → DONE.
    - If k>6: output keep 0xFF, tlast=0, → TAIL.
  - TAIL: one beat {carry bytes 0..k-7}, keep = (1<<(k-6))-1, tlast=1 → DONE.
  - DONE: wait for the tlast handshake, then → IDLE.
- **Reset.** Assertion, including mid-frame, forces IDLE immediately. The in-flight frame is abandoned and the downstream frame is truncated.
- **Reset values.** `hdr_ready`=0, `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `busy`=0.

## Timing
- **First beat after reset.** `hdr_ready` rises on the first clk edge after `rst` is released.
- **Header latency.** Header accepted at edge T → beat 0 has `m_axis_tvalid`=1 after edge T+1. The checksum is registered by T+2, before beat 3 can issue.
- **Output register.** `m_axis_*` is a single output register. Data, keep and last are held stable while tvalid && !tready. tvalid never drops without a handshake.
- **Throughput.** With tready held high, one beat per cycle, 4 header beats, then one beat per accepted input beat. `hdr_ready` stays low from accept until one cycle after the final tlast handshake, then is high in IDLE. Minimum gap between frames is one cycle.
- **Simultaneous events.** In MERGE, input accept and output handshake in the same cycle is legal and gives full rate. No input beat is lost or duplicated under any tready pattern.

## Test plan
- **Checksum frame.** Header: src c0a80001, dst c0a800c7, TTL 0x40, protocol 0x11, id 0, dscp/ecn 0, length 95. Payload 95 bytes of incrementing 0x00.. → total length 0x0073, checksum bytes B8 61, 17 beats, last keep 0x01. Byte 34 = 0x00, byte 128 = 0x5E.
- **Exact fit.** 6-byte payload (keep 0x3F, tlast) → 5 beats; beat 4 keep 0xFF, tlast, bytes 2-7 = payload.
- **TAIL case.** 7-byte payload → 6 beats; beat 4 keep 0xFF tlast=0; beat 5 keep 0x01 tlast=1, holding payload byte 6.
- **Backpressure.** `m_axis_tready` alternating 1/0 and `s_axis_tvalid` random on frame 1 → byte stream identical to frame 1. Never `s_axis_tready`=1 while output is stalled.
- **Reset mid-payload.** `rst`=0 during MERGE → `m_axis_tvalid`=0 and `busy`=0 without a clock edge. After release, the next frame is byte-exact.
- **Back-to-back descriptors.** `hdr_valid` held for 2 descriptors → second accepted only after first tlast handshake plus 1 cycle. Second frame's beat 0 follows its accept by one edge, and the src IP reflects `configurable_ipv4_address` changed mid-frame 1.

Source files
------------

// File: rtl/mat_ipv4_header_builder.sv
// Purpose: prepends a 34-byte Ethernet II + IPv4 header to a payload stream, realigning the payload by 2 bytes.
// Latency: beat 0 leaves one edge after header accept; each payload beat leaves one edge after it is accepted.
// Backpressure: single output register; payload tready only while that register is empty or draining.
module mat_ipv4_header_builder #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                configurable_ipv4_address,
  input  logic                       hdr_valid,
  output logic                       hdr_ready,
  input  logic [47:0]                hdr_mac_dest,
  input  logic [47:0]                hdr_mac_src,
  input  logic [5:0]                 hdr_dscp,
  input  logic [1:0]                 hdr_ecn,
  input  logic [15:0]                hdr_identifiant,
  input  logic [7:0]                 hdr_ttl,
  input  logic [7:0]                 hdr_protocol,
  input  logic [31:0]                hdr_dest_ipv4,
  input  logic [15:0]                hdr_payload_length,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_MERGE, S_TAIL, S_DONE} state_t;
  state_t state_q, state_d;

  // Descriptor fields captured at accept
  logic [47:0]  mac_dst_q, mac_src_q;
  logic [7:0]   tos_q, ttl_q, proto_q;
  logic [15:0]  id_q, tot_len_q, csum_q, carry_q;
  logic [31:0]  src_ip_q, dst_ip_q;
  logic [1:0]   beat_cnt_q;
  logic [3:0]   tail_k_q;
  logic         hdr_ready_q;

  logic [31:0]  csum_sum, csum_f1, csum_f2;
  logic [271:0] hdr_wire, hdr_lanes;
  logic [63:0]  hdr_beat;
  logic [3:0]   in_k;
  logic         out_free, accept, in_take, out_load;
  logic [63:0]  out_dat_d;
  logic [7:0]   out_keep_d;
  logic         out_last_d;

  assign hdr_ready     = hdr_ready_q;
  assign busy          = (state_q != S_IDLE);
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_q == S_MERGE) && out_free;
  assign in_k          = 4'($countones(s_axis_tkeep));

  // Header checksum over the registered fields; checksum word itself counted as zero
  assign csum_sum = 32'h0000_4500 + {24'd0, tos_q} + {16'd0, tot_len_q} + {16'd0, id_q}
                  + 32'h0000_4000 + {16'd0, ttl_q, proto_q}
                  + {16'd0, src_ip_q[31:16]} + {16'd0, src_ip_q[15:0]}
                  + {16'd0, dst_ip_q[31:16]} + {16'd0, dst_ip_q[15:0]};
  assign csum_f1  = {16'd0, csum_sum[15:0]} + {16'd0, csum_sum[31:16]};
  assign csum_f2  = {16'd0, csum_f1[15:0]} + {16'd0, csum_f1[31:16]};

  // Header in wire order, most significant byte first on the wire
  assign hdr_wire = {mac_dst_q, mac_src_q, 16'h0800, 8'h45, tos_q, tot_len_q, id_q,
                     16'h4000, ttl_q, proto_q, csum_q, src_ip_q, dst_ip_q};

  // Re-pack so that wire byte i sits in lane position i
  always_comb begin
    hdr_lanes = '0;
    for (int i = 0; i < 34; i++) begin
      hdr_lanes[i*8 +: 8] = hdr_wire[271 - i*8 -: 8];
    end
  end

  // Select the header beat being issued
  always_comb begin
    case (beat_cnt_q)
      2'd0:    hdr_beat = hdr_lanes[63:0];
      2'd1:    hdr_beat = hdr_lanes[127:64];
      2'd2:    hdr_beat = hdr_lanes[191:128];
      default: hdr_beat = hdr_lanes[255:192];
    endcase
  end

  // Next-state and output-register load decisions
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    in_take    = 1'b0;
    out_load   = 1'b0;
    out_dat_d  = m_axis_tdata;
    out_keep_d = m_axis_tkeep;
    out_last_d = m_axis_tlast;
    case (state_q)
      S_IDLE: begin
        if (hdr_valid && hdr_ready_q) begin
          accept  = 1'b1;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_dat_d  = hdr_beat;
          out_keep_d = 8'hFF;
          out_last_d = 1'b0;
          if (beat_cnt_q == 2'd3) state_d = S_MERGE;
        end
      end
      S_MERGE: begin
        if (s_axis_tvalid && out_free) begin
          in_take    = 1'b1;
          out_load   = 1'b1;
          out_dat_d  = {s_axis_tdata[47:0], carry_q};
          out_keep_d = 8'hFF;
          out_last_d = 1'b0;
          if (s_axis_tlast) begin
            if (in_k <= 4'd6) begin
              out_keep_d = 8'((9'd1 << (in_k + 4'd2)) - 9'd1);
              out_last_d = 1'b1;
              state_d    = S_DONE;
            end else begin
              state_d    = S_TAIL;
            end
          end
        end
      end
      S_TAIL: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_dat_d  = {48'd0, carry_q};
          out_keep_d = 8'((9'd1 << (tail_k_q - 4'd6)) - 9'd1);
          out_last_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; hdr_ready is registered so it only rises one edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hdr_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_ready_q <= (state_d == S_IDLE);
    end
  end

  // Descriptor capture, header beat counter, realignment carry and checksum register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_dst_q  <= '0;
      mac_src_q  <= '0;
      tos_q      <= '0;
      ttl_q      <= '0;
      proto_q    <= '0;
      id_q       <= '0;
      tot_len_q  <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      csum_q     <= '0;
      carry_q    <= '0;
      beat_cnt_q <= '0;
      tail_k_q   <= '0;
    end else begin
      csum_q <= ~csum_f2[15:0];
      if (accept) begin
        mac_dst_q  <= hdr_mac_dest;
        mac_src_q  <= hdr_mac_src;
        tos_q      <= {hdr_dscp, hdr_ecn};
        ttl_q      <= hdr_ttl;
        proto_q    <= hdr_protocol;
        id_q       <= hdr_identifiant;
        tot_len_q  <= hdr_payload_length + 16'd20;
        src_ip_q   <= configurable_ipv4_address;
        dst_ip_q   <= hdr_dest_ipv4;
        beat_cnt_q <= 2'd0;
      end
      if (state_q == S_HEADER && out_load) begin
        beat_cnt_q <= beat_cnt_q + 2'd1;
        // Last two header bytes (dst IP bytes 2-3) lead the first payload beat
        if (beat_cnt_q == 2'd3) carry_q <= hdr_lanes[271:256];
      end
      if (in_take) begin
        carry_q <= s_axis_tdata[63:48];
        if (s_axis_tlast) tail_k_q <= in_k;
      end
    end
  end

  // Output register: reload only when empty or draining, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_dat_d;
      m_axis_tkeep  <= out_keep_d;
      m_axis_tlast  <= out_last_d;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
